// File: rtl/io_pkg.sv
// Shared definitions for the IO tile family: register indices, opcodes,
// config_addr field positions and the opcode decoder.
package io_pkg;

  localparam logic [7:0] IO_REG_DIR    = 8'd0;
  localparam logic [7:0] IO_REG_OREG   = 8'd1;
  localparam logic [7:0] IO_REG_INV    = 8'd2;
  localparam logic [7:0] IO_REG_STATUS = 8'd3;

  localparam logic [7:0] IO_OP_WRITE = 8'h00;
  localparam logic [7:0] IO_OP_READ  = 8'h01;

  localparam int unsigned CFG_ID_LSB  = 0;
  localparam int unsigned CFG_ID_MSB  = 15;
  localparam int unsigned CFG_IDX_LSB = 16;
  localparam int unsigned CFG_IDX_MSB = 23;
  localparam int unsigned CFG_OP_LSB  = 24;
  localparam int unsigned CFG_OP_MSB  = 31;

  typedef enum logic [1:0] {
    CFG_IDLE,
    CFG_WRITE,
    CFG_READ
  } cfg_cmd_e;

  // Unknown opcodes map to CFG_IDLE so they never touch tile state.
  function automatic cfg_cmd_e decode_cmd(input logic [7:0] op);
    case (op)
      IO_OP_WRITE: return CFG_WRITE;
      IO_OP_READ:  return CFG_READ;
      default:     return CFG_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/io_nbit_tile_if.sv
// Shared configuration bus of the IO tile array: address/data broadcast by
// the configuration master, registered readback returned by the tile.
interface io_nbit_tile_if;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic [31:0] read_data;

  modport master (
    output config_addr,
    output config_data,
    input  read_data
  );

  modport slave (
    input  config_addr,
    input  config_data,
    output read_data
  );
endinterface

// File: rtl/io_bit_input.sv
// Input path of one pad bit: synchroniser chain, optional glitch filter,
// programmable inversion. The filter exists only when IO_GLITCH_FILTER_EN
// is defined; otherwise FILTER_CYCLES is not used by this module.
module io_bit_input #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pad_in,
  input  logic inv,
  output logic p2f,
  output logic status
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  // Synchroniser shift chain, stage 0 samples the pad.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= pad_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef IO_GLITCH_FILTER_EN
  logic [3:0] cnt_q;
  logic       filt_q;

  // Adopt the synchronised level only after it has differed for FILTER_CYCLES edges in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync_out != filt_q) begin
      if (cnt_q == 4'(FILTER_CYCLES - 1)) begin
        filt_q <= sync_out;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign status = filt_q;
`else
  assign status = sync_out;
`endif

  assign p2f = status ^ inv;

endmodule

// File: rtl/io_nbit_tile.sv
// WIDTH-bit bidirectional IO tile: per-bit direction, registered/bypass
// output, inverted input, synchronised pad sampling and config readback.
// Optional glitch filter on the input path: define IO_GLITCH_FILTER_EN.
module io_nbit_tile
  import io_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] pad,
  output logic [WIDTH-1:0] p2f,
  input  logic [WIDTH-1:0] f2p,
  input  logic [15:0]      tile_id,
  io_nbit_tile_if.slave    cfg
);

  localparam bit PARAMS_OK = (WIDTH >= 1) && (WIDTH <= 32) &&
                             (SYNC_STAGES >= 1) && (SYNC_STAGES <= 4) &&
                             (FILTER_CYCLES >= 2) && (FILTER_CYCLES <= 15);

  if (!PARAMS_OK) begin : g_bad_params
    $error("io_nbit_tile: parameter out of range");
  end

  logic [15:0]      addr_id;
  logic [7:0]       addr_idx;
  logic [7:0]       addr_op;
  logic [WIDTH-1:0] wdata;
  cfg_cmd_e         cmd;

  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] oreg_q;
  logic [WIDTH-1:0] inv_q;
  logic [WIDTH-1:0] f2p_q;
  logic [WIDTH-1:0] drv;
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] rd_sel;

  assign addr_id  = cfg.config_addr[CFG_ID_MSB:CFG_ID_LSB];
  assign addr_idx = cfg.config_addr[CFG_IDX_MSB:CFG_IDX_LSB];
  assign addr_op  = cfg.config_addr[CFG_OP_MSB:CFG_OP_LSB];
  assign wdata    = cfg.config_data[WIDTH-1:0];

  // Decode the bus into a command for this tile; reset masks any hit.
  always_comb begin
    cmd = CFG_IDLE;
    if (!reset && (addr_id == tile_id) && (addr_idx <= IO_REG_STATUS)) begin
      cmd = decode_cmd(addr_op);
    end
  end

  // Configuration registers; STATUS is read-only so writes to it fall through.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q  <= '0;
      oreg_q <= '0;
      inv_q  <= '0;
    end else if (cmd == CFG_WRITE) begin
      case (addr_idx)
        IO_REG_DIR:  dir_q  <= wdata;
        IO_REG_OREG: oreg_q <= wdata;
        IO_REG_INV:  inv_q  <= wdata;
        default:     ;
      endcase
    end
  end

  // Registered copy of the fabric drive value for the registered output mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      f2p_q <= '0;
    end else begin
      f2p_q <= f2p;
    end
  end

  // Per-bit choice between bypass and registered drive value.
  always_comb begin
    drv = (oreg_q & f2p_q) | (~oreg_q & f2p);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign pad[i] = dir_q[i] ? drv[i] : 1'bz;

    io_bit_input #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_in (
      .clk    (clk),
      .reset  (reset),
      .pad_in (pad[i]),
      .inv    (inv_q[i]),
      .p2f    (p2f[i]),
      .status (status[i])
    );
  end

  // Readback source selected by register index.
  always_comb begin
    rd_sel = '0;
    case (addr_idx)
      IO_REG_DIR:    rd_sel = dir_q;
      IO_REG_OREG:   rd_sel = oreg_q;
      IO_REG_INV:    rd_sel = inv_q;
      IO_REG_STATUS: rd_sel = status;
      default:       rd_sel = '0;
    endcase
  end

  // Readback register: holds data only in the cycle after a read hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg.read_data <= '0;
    end else if (cmd == CFG_READ) begin
      cfg.read_data <= 32'(rd_sel);
    end else begin
      cfg.read_data <= '0;
    end
  end

endmodule

// File: tb/tb_io_nbit_tile.sv
// Bench for io_nbit_tile: directed scenarios followed by randomized traffic,
// checked against a cycle-level reference model of the tile's rules.
module tb_io_nbit_tile;
  import io_pkg::*;

  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam logic [15:0] MY_ID = 16'h1A2B;

  logic          clk = 1'b0;
  logic          reset;
  wire  [W-1:0]  pad;
  logic [W-1:0]  p2f;
  logic [W-1:0]  f2p;
  logic [W-1:0]  ext_val;
  logic [W-1:0]  ext_en;
  logic [15:0]   tile_id;

  io_nbit_tile_if cfg ();

  always #5 clk = ~clk;

  for (genvar i = 0; i < W; i++) begin : g_ext
    assign pad[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  io_nbit_tile #(
    .WIDTH         (W),
    .SYNC_STAGES   (SYNC),
    .FILTER_CYCLES (FILT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pad     (pad),
    .p2f     (p2f),
    .f2p     (f2p),
    .tile_id (tile_id),
    .cfg     (cfg.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [W-1:0]  dir_m  = '0;
  logic [W-1:0]  oreg_m = '0;
  logic [W-1:0]  inv_m  = '0;
  logic [W-1:0]  f2pq_m = '0;
  logic [31:0]   rd_m   = '0;
  logic [W-1:0]  hist[$];
  logic [W-1:0]  filt_m = '0;
  logic [W-1:0]  sq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Level the input path reports as STATUS right now.
  function automatic logic [W-1:0] exp_status();
`ifdef IO_GLITCH_FILTER_EN
    return filt_m;
`else
    return hist[hist.size() - SYNC];
`endif
  endfunction

  task automatic bus(input logic [7:0] op, input logic [7:0] idx, input bit match,
                     input logic [31:0] data);
    logic [15:0] id;
    id = match ? MY_ID : (MY_ID ^ 16'h0001);
    cfg.config_addr = {op, idx, id};
    cfg.config_data = data;
  endtask

  task automatic idle();
    bus(8'hFF, IO_REG_DIR, 1'b1, 32'hFFFF_FFFF);
  endtask

  // One clock cycle: check pad combinationally, advance the model across the
  // edge, then check p2f and read_data after the edge.
  task automatic cycle();
    logic [W-1:0] pexp;
    logic [W-1:0] st_pre;
    logic [W-1:0] sync_pre;
    logic [7:0]   op;
    logic [7:0]   idx;
    logic [W-1:0] wd;
    bit           hit;
    bit           all_diff;
    #2;
    for (int b = 0; b < W; b++)
      pexp[b] = dir_m[b] ? (oreg_m[b] ? f2pq_m[b] : f2p[b]) : ext_val[b];
    chk("pad", 32'(pad), 32'(pexp));
    @(posedge clk);
    st_pre   = exp_status();
    sync_pre = hist[hist.size() - SYNC];
    op  = cfg.config_addr[31:24];
    idx = cfg.config_addr[23:16];
    wd  = cfg.config_data[W-1:0];
    hit = !reset && (cfg.config_addr[15:0] == tile_id) && (idx <= 8'd3);
    rd_m = '0;
    if (reset) begin
      dir_m = '0; oreg_m = '0; inv_m = '0; f2pq_m = '0; filt_m = '0;
      sq.delete();
      for (int k = 0; k < SYNC; k++) hist.push_back('0);
    end else begin
      if (hit && op == IO_OP_READ) begin
        case (idx)
          8'd0: rd_m = 32'(dir_m);
          8'd1: rd_m = 32'(oreg_m);
          8'd2: rd_m = 32'(inv_m);
          default: rd_m = 32'(st_pre);
        endcase
      end
      if (hit && op == IO_OP_WRITE) begin
        if (idx == 8'd0) dir_m = wd;
        if (idx == 8'd1) oreg_m = wd;
        if (idx == 8'd2) inv_m = wd;
      end
      f2pq_m = f2p;
      hist.push_back(pexp);
      sq.push_back(sync_pre);
      if (sq.size() >= FILT) begin
        for (int b = 0; b < W; b++) begin
          all_diff = 1'b1;
          for (int k = 1; k <= FILT; k++)
            if (sq[sq.size() - k][b] == filt_m[b]) all_diff = 1'b0;
          if (all_diff) filt_m[b] = ~filt_m[b];
        end
      end
    end
    while (hist.size() > 16) void'(hist.pop_front());
    while (sq.size() > 32) void'(sq.pop_front());
    #1;
    ext_en = ~dir_m;
    chk("p2f", 32'(p2f), 32'(exp_status() ^ inv_m));
    chk("read_data", cfg.read_data, rd_m);
  endtask

  initial begin
    for (int k = 0; k < SYNC; k++) hist.push_back('0);
    reset   = 1'b1;
    tile_id = MY_ID;
    f2p     = '1;
    ext_val = '0;
    ext_en  = '1;
    idle();
    #1;
    // Reset state
    cycle(); cycle();
    reset = 1'b0;

    // Write with wrong tile id must not enable any driver
    bus(IO_OP_WRITE, IO_REG_DIR, 1'b0, 32'h0000_00FF);
    cycle();
    idle();
    cycle(); cycle();

    // Bypass output on low nibble, loopback into p2f
    bus(IO_OP_WRITE, IO_REG_DIR, 1'b1, 32'h0000_000F);
    cycle();
    bus(IO_OP_WRITE, IO_REG_OREG, 1'b1, 32'h0000_0000);
    f2p = 8'h05;
    ext_val = 8'h50;
    cycle();
    idle();
    for (int k = 0; k < 4; k++) cycle();
    for (int k = 0; k < 6; k++) begin
      f2p = W'($urandom); ext_val = W'($urandom);
      cycle();
    end

    // Registered bit 0 vs bypass bit
    bus(IO_OP_WRITE, IO_REG_OREG, 1'b1, 32'h0000_0001);
    cycle();
    bus(IO_OP_WRITE, IO_REG_DIR, 1'b1, 32'h0000_0003);
    f2p = 8'h00;
    cycle();
    idle();
    cycle();
    f2p = 8'h03;
    cycle(); cycle();
    f2p = 8'h00;
    cycle(); cycle();

    // Inversion with all pads as inputs, then STATUS readback
    bus(IO_OP_WRITE, IO_REG_INV, 1'b1, 32'hFFFF_FFFF);
    cycle();
    bus(IO_OP_WRITE, IO_REG_DIR, 1'b1, 32'h0000_0000);
    cycle();
    idle();
    ext_val = 8'hA5;
    for (int k = 0; k < SYNC + FILT + 1; k++) cycle();
    bus(IO_OP_READ, IO_REG_STATUS, 1'b1, 32'h0);
    cycle();
    bus(IO_OP_READ, IO_REG_INV, 1'b1, 32'h0);
    cycle();
    bus(IO_OP_WRITE, IO_REG_STATUS, 1'b1, 32'h0000_0000);
    cycle();
    idle();
    cycle();

`ifdef IO_GLITCH_FILTER_EN
    // Short pulses are swallowed, a FILT-cycle pulse passes
    ext_val = 8'h00;
    for (int k = 0; k < SYNC + FILT + 1; k++) cycle();
    for (int len = 1; len <= FILT; len++) begin
      ext_val = 8'h01;
      for (int k = 0; k < len; k++) cycle();
      ext_val = 8'h00;
      for (int k = 0; k < SYNC + FILT + 2; k++) cycle();
    end
`endif

    // Reset coinciding with a write hit
    bus(IO_OP_WRITE, IO_REG_DIR, 1'b1, 32'h0000_00FF);
    f2p = 8'hFF;
    ext_val = 8'h00;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    idle();
    cycle(); cycle();
    bus(IO_OP_READ, IO_REG_DIR, 1'b1, 32'h0);
    cycle();
    idle();
    cycle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [7:0] op;
      case ($urandom_range(0, 4))
        0, 1: op = IO_OP_WRITE;
        2, 3: op = IO_OP_READ;
        default: op = 8'(($urandom_range(2, 255)));
      endcase
      bus(op, 8'($urandom_range(0, 4)), ($urandom_range(0, 3) != 0), $urandom);
      reset   = ($urandom_range(0, 49) == 0);
      f2p     = W'($urandom);
      ext_val = ($urandom_range(0, 2) == 0) ? W'($urandom) : ext_val;
      cycle();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
